// File: rtl/pio_edge_in_filt.sv
// rtl/pio_edge_in_filt.sv - input PIO with synchroniser, glitch filter, edge capture and irq
module pio_edge_in_filt #(
    parameter int              WIDTH       = 8,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_CNT    = 3,
    parameter int              DB_W        = 16,
    parameter logic [DB_W-1:0] DB_RESET    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0][3:0]             r_cnt;
    logic [WIDTH-1:0]                  r_filt;
    logic [WIDTH-1:0]                  r_filt_d;
    logic [WIDTH-1:0]                  r_rise_en;
    logic [WIDTH-1:0]                  r_fall_en;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_cap;
    logic [DB_W-1:0]                   r_dbnc;
    logic [DB_W-1:0]                   r_pre;

    logic             w_wr;
    logic             w_wr_dbnc;
    logic             w_tick;
    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_wr       = chipselect & ~write_n;
    assign w_wr_dbnc  = w_wr && (address == 3'd5);
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_tick     = (r_pre == r_dbnc);
    assign w_ev       = (r_filt & ~r_filt_d & r_rise_en) | (~r_filt & r_filt_d & r_fall_en);
    assign w_clr      = (w_wr && (address == 3'd3)) ? writedata[WIDTH-1:0] : '0;
    assign irq        = |(r_cap & r_mask);
    assign w_unused   = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_wr_dbnc || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Each bit must disagree with the accepted value for FILT_CNT ticks in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_dbnc == '0) begin
                    r_filt[i] <= w_sync_out[i];
                    r_cnt[i]  <= 4'd0;
                end else if (w_sync_out[i] == r_filt[i]) begin
                    r_cnt[i] <= 4'd0;
                end else if (w_tick) begin
                    if (r_cnt[i] == 4'(FILT_CNT - 1)) begin
                        r_filt[i] <= w_sync_out[i];
                        r_cnt[i]  <= 4'd0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 4'd1;
                    end
                end
                if (w_wr_dbnc) begin
                    r_cnt[i] <= 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_d <= '0;
        end else begin
            r_filt_d <= r_filt;
        end
    end

    // A new event on the clearing edge survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_ev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise_en <= '1;
            r_mask    <= '0;
            r_fall_en <= '0;
            r_dbnc    <= DB_RESET;
        end else if (w_wr) begin
            case (address)
                3'd1:    r_rise_en <= writedata[WIDTH-1:0];
                3'd2:    r_mask    <= writedata[WIDTH-1:0];
                3'd4:    r_fall_en <= writedata[WIDTH-1:0];
                3'd5:    r_dbnc    <= writedata[DB_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            3'd0:    w_rdata = 32'(r_filt);
            3'd1:    w_rdata = 32'(r_rise_en);
            3'd2:    w_rdata = 32'(r_mask);
            3'd3:    w_rdata = 32'(r_cap);
            3'd4:    w_rdata = 32'(r_fall_en);
            3'd5:    w_rdata = 32'(r_dbnc);
            3'd6:    w_rdata = 32'(w_sync_out);
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_pio_edge_in_filt.sv
// tb/tb_pio_edge_in_filt.sv - directed table-driven bench for pio_edge_in_filt
module tb_pio_edge_in_filt;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_port = '0;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    pio_edge_in_filt #(
        .WIDTH(8), .SYNC_STAGES(2), .FILT_CNT(3), .DB_W(16), .DB_RESET(16'd0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] rst_exp [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] d;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check($sformatf("%s_addr%0d", tag, a), d, rst_exp[a]);
            check($sformatf("%s_irq%0d", tag, a), {31'd0, irq}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        int          first;
        logic        seen;

        rst_exp = '{32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        // reset values, then register read/write behaviour
        for (int a = 0; a < 8; a++) vecs.push_back('{1'b0, 3'(a), 32'h0, rst_exp[a], 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'hFFFF_FF5A, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0000_005A, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_013C, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h0000_003C, 1'b0});
        vecs.push_back('{1'b1, 3'd4, 32'h1234_56A5, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_00A5, 1'b0});
        vecs.push_back('{1'b1, 3'd5, 32'h0001_2345, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0000_2345, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd7, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd6, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_00FF, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd4, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 3'd5, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0, 1'b0});

        wait_clk(3);
        check("irq_in_reset", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr, d);
                check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
                check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            end
        end

        // bypass latency: capture and irq exactly at the 4th edge
        wr(3'd2, 32'h01);
        @(negedge clk);
        in_port = 8'h01;
        repeat (3) @(posedge clk);
        #1 check("bypass_irq_edge3", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 check("bypass_irq_edge4", {31'd0, irq}, 32'd1);
        rd(3'd3, d); check("bypass_capture", d, 32'h01);
        rd(3'd0, d); check("bypass_data", d, 32'h01);
        rd(3'd6, d); check("bypass_raw", d, 32'h01);
        wr(3'd3, 32'h01);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        rd(3'd3, d); check("w1c_capture", d, 32'h00);
        in_port = 8'h00;
        wait_clk(6);
        rd(3'd3, d); check("no_fall_event", d, 32'h00);

        // falling-only edge select
        wr(3'd1, 32'h00);
        wr(3'd4, 32'h80);
        in_port = 8'h80;
        wait_clk(6);
        rd(3'd3, d); check("fall_rise_ignored", d, 32'h00);
        in_port = 8'h00;
        wait_clk(6);
        rd(3'd3, d); check("fall_capture", d, 32'h80);
        check("fall_irq_masked", {31'd0, irq}, 32'd0);
        wr(3'd2, 32'h80);
        check("unmask_irq", {31'd0, irq}, 32'd1);
        wr(3'd2, 32'h00);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'hFF);
        wr(3'd4, 32'h00);
        rd(3'd3, d); check("fall_cleared", d, 32'h00);

        // glitch filter: DBNC=9, FILT_CNT=3
        wr(3'd5, 32'd9);
        wait_clk(5);
        address = 3'd0;
        seen = 1'b0;
        in_port = 8'h01;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (readdata[0]) seen = 1'b1;
        end
        in_port = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (readdata[0]) seen = 1'b1;
        end
        check("glitch_data_stayed_0", {31'd0, seen}, 32'd0);
        rd(3'd3, d); check("glitch_no_capture", d, 32'h00);

        address = 3'd0;
        @(negedge clk);
        in_port = 8'h01;
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (readdata[0] && first < 0) first = c;
        end
        in_port = 8'h00;
        n_checks++;
        if (first >= 24 && first <= 33) n_pass++;
        else $display("FAIL filt_latency: first seen at clock %0d expected 24..33", first);
        rd(3'd3, d); check("filt_capture", d, 32'h01);
        wr(3'd3, 32'h01);
        wait_clk(40);
        rd(3'd3, d); check("filt_single_event", d, 32'h00);
        rd(3'd0, d); check("filt_data_back_0", d, 32'h00);

        // collision: set on the same edge as W1C wins
        wr(3'd5, 32'd0);
        in_port = 8'h06;
        wait_clk(6);
        rd(3'd3, d); check("coll_setup", d, 32'h06);
        in_port = 8'h00;
        wait_clk(6);
        @(negedge clk);
        in_port = 8'h02;
        wait_clk(3);
        address = 3'd3; writedata = 32'h06; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        rd(3'd3, d); check("coll_set_wins", d, 32'h02);
        in_port = 8'h00;

        // reset in the middle of filtering
        wr(3'd5, 32'd9);
        wr(3'd2, 32'hFF);
        wr(3'd3, 32'hFF);
        in_port = 8'h01;
        wait_clk(12);
        #2 reset_n = 1'b0;
        in_port = 8'h00;
        #1 check("rst_async_irq", {31'd0, irq}, 32'd0);
        check("rst_async_rdata", readdata, 32'd0);
        wait_clk(3);
        reset_n = 1'b1;
        check_reset_regs("rst_mid");
        wait_clk(10);
        rd(3'd3, d); check("rst_mid_no_event", d, 32'h00);

        @(negedge clk);
        reset_n = 1'b0;
        in_port = 8'h01;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(6);
        rd(3'd3, d); check("rst_high_event", d, 32'h01);
        rd(3'd0, d); check("rst_high_data", d, 32'h01);
        wr(3'd3, 32'h01);
        wait_clk(6);
        rd(3'd3, d); check("rst_high_single", d, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
